// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect definitions: arbiter FSM states and RRESP codes.
package axil_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_rr_arbiter.sv
// Combinational round-robin picker shared by the read and write arbiters.
// Define AXIL_ARB_RD_FIXED_PRIO_EN for fixed priority (lowest index wins, last_grant ignored).
module axil_rr_arbiter
  import axil_pkg::*;
#(
  parameter int unsigned NUMBER_MASTER = 2
) (
  input  logic [NUMBER_MASTER-1:0]         req,
  input  logic [$clog2(NUMBER_MASTER)-1:0] last_grant,
  output logic [$clog2(NUMBER_MASTER)-1:0] grant,
  output logic                             any_req
);

  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

  int unsigned base;
  int unsigned cand;

`ifdef AXIL_ARB_RD_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_grant;
  assign base        = 0;
`else
  assign base = 32'(last_grant) + 1;
`endif

  // Scan NUMBER_MASTER positions starting at base; the first set request wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
      cand = (base + i) % NUMBER_MASTER;
      if (!any_req && req[cand[IDX_W-1:0]]) begin
        grant   = cand[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_rd.sv
// AXI-Lite read arbiter/mux: one master at a time owns the slave AR and R channels.
// Define AXIL_ARB_RD_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module axil_arbiter_rd
  import axil_pkg::*;
#(
  parameter int unsigned NUMBER_MASTER  = 2,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  output logic [$clog2(NUMBER_MASTER)-1:0] grant_rd,
  output logic                             grant_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]        m_axil_araddr [NUMBER_MASTER],
  input  logic [NUMBER_MASTER-1:0]         m_axil_arvalid,
  output logic [NUMBER_MASTER-1:0]         m_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]        m_axil_rdata  [NUMBER_MASTER],
  output logic [1:0]                       m_axil_rresp  [NUMBER_MASTER],
  output logic [NUMBER_MASTER-1:0]         m_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0]         m_axil_rready,
  output logic [AXI_ADDR_WIDTH-1:0]        s_axil_araddr,
  output logic                             s_axil_arvalid,
  input  logic                             s_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]        s_axil_rdata,
  input  logic [1:0]                       s_axil_rresp,
  input  logic                             s_axil_rvalid,
  output logic                             s_axil_rready
);

  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] grant_next, last_grant, last_next, winner;
  logic             any_req;

  axil_rr_arbiter #(
    .NUMBER_MASTER(NUMBER_MASTER)
  ) u_arb (
    .req       (m_axil_arvalid),
    .last_grant(last_grant),
    .grant     (winner),
    .any_req   (any_req)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant_rd   <= '0;
      last_grant <= IDX_W'(NUMBER_MASTER - 1);
    end else begin
      state      <= state_next;
      grant_rd   <= grant_next;
      last_grant <= last_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = grant_rd;
    last_next      = last_grant;
    grant_valid    = 1'b0;
    s_axil_araddr  = '0;
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b0;
    m_axil_arready = '0;
    m_axil_rvalid  = '0;
    m_axil_rdata   = '{default: '0};
    m_axil_rresp   = '{default: '0};
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_next = winner;
          state_next = ADDR;
        end
      end
      ADDR: begin
        grant_valid              = 1'b1;
        s_axil_arvalid           = m_axil_arvalid[grant_rd];
        s_axil_araddr            = m_axil_araddr[grant_rd];
        m_axil_arready[grant_rd] = s_axil_arready;
        if (m_axil_arvalid[grant_rd] && s_axil_arready) state_next = DATA;
      end
      DATA: begin
        grant_valid             = 1'b1;
        m_axil_rvalid[grant_rd] = s_axil_rvalid;
        m_axil_rdata[grant_rd]  = s_axil_rdata;
        m_axil_rresp[grant_rd]  = s_axil_rresp;
        s_axil_rready           = m_axil_rready[grant_rd];
        if (s_axil_rvalid && m_axil_rready[grant_rd]) begin
`ifndef AXIL_ARB_RD_FIXED_PRIO_EN
          last_next = grant_rd;
`endif
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter_rd.sv
// Self-checking bench for axil_arbiter_rd with three masters and a scripted/random slave.
module tb_axil_arbiter_rd;
  import axil_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] grant_rd;
  logic          grant_valid;
  logic [AW-1:0] m_araddr [N];
  logic [N-1:0]  m_arvalid, m_arready;
  logic [DW-1:0] m_rdata [N];
  logic [1:0]    m_rresp [N];
  logic [N-1:0]  m_rvalid, m_rready;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid, s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid, s_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last;

  always #5 clk = ~clk;

  axil_arbiter_rd #(
    .NUMBER_MASTER (N),
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW)
  ) dut (
    .aclk          (clk),
    .aresetn       (rst_n),
    .grant_rd      (grant_rd),
    .grant_valid   (grant_valid),
    .m_axil_araddr (m_araddr),
    .m_axil_arvalid(m_arvalid),
    .m_axil_arready(m_arready),
    .m_axil_rdata  (m_rdata),
    .m_axil_rresp  (m_rresp),
    .m_axil_rvalid (m_rvalid),
    .m_axil_rready (m_rready),
    .s_axil_araddr (s_araddr),
    .s_axil_arvalid(s_arvalid),
    .s_axil_arready(s_arready),
    .s_axil_rdata  (s_rdata),
    .s_axil_rresp  (s_rresp),
    .s_axil_rvalid (s_rvalid),
    .s_axil_rready (s_rready)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Reference arbitration: who should own the slave given the pending set.
  function automatic int exp_winner(input logic [N-1:0] req, input int last);
`ifdef AXIL_ARB_RD_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic outs_zero();
    logic z;
    z = !grant_valid && !s_arvalid && (s_araddr == '0) && !s_rready &&
        (m_arready == '0) && (m_rvalid == '0);
    for (int i = 0; i < N; i++) z &= (m_rdata[i] == '0) && (m_rresp[i] == '0);
    return z;
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    m_arvalid = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = N - 1;
  endtask

  // Called at a negedge with the DUT idle and requests set; runs one full transaction for master g.
  task automatic do_txn(input int g, input int ar_dly, input int r_dly, input int rr_dly,
                        input logic [DW-1:0] data, input logic [1:0] resp);
    logic [AW-1:0] addr;
    logic [N-1:0]  exp_vec;
    bit            done;
    addr = m_araddr[g];
    for (int k = 0; k <= ar_dly; k++) begin
      @(posedge clk); #1;
      s_arready = (k == ar_dly);
      @(negedge clk);
      exp_vec    = '0;
      exp_vec[g] = s_arready;
      n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL addr_grant_valid: got %b, expected 1", grant_valid); end
      n_checks++; if (grant_rd !== IW'(g)) begin n_fail++; $display("FAIL addr_grant_rd: got %0d, expected %0d", grant_rd, g); end
      n_checks++; if (s_arvalid !== 1'b1) begin n_fail++; $display("FAIL s_arvalid: got %b, expected 1", s_arvalid); end
      n_checks++; if (s_araddr !== addr) begin n_fail++; $display("FAIL s_araddr: got %h, expected %h", s_araddr, addr); end
      n_checks++; if (m_arready !== exp_vec) begin n_fail++; $display("FAIL m_arready: got %b, expected %b", m_arready, exp_vec); end
      n_checks++; if (s_rready !== 1'b0 || m_rvalid !== '0) begin n_fail++; $display("FAIL addr_r_quiet: got rready=%b rvalid=%b, expected 0", s_rready, m_rvalid); end
    end
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        s_arready    = 1'b0;
        m_arvalid[g] = 1'b0;
      end
      s_rvalid    = (k >= r_dly);
      s_rdata     = data;
      s_rresp     = resp;
      m_rready[g] = (k >= rr_dly);
      @(negedge clk);
      exp_vec    = '0;
      exp_vec[g] = s_rvalid;
      n_checks++; if (grant_valid !== 1'b1 || grant_rd !== IW'(g)) begin n_fail++; $display("FAIL data_grant: got valid=%b idx=%0d, expected 1/%0d", grant_valid, grant_rd, g); end
      n_checks++; if (s_arvalid !== 1'b0 || m_arready !== '0) begin n_fail++; $display("FAIL data_ar_quiet: got arvalid=%b arready=%b, expected 0", s_arvalid, m_arready); end
      n_checks++; if (m_rvalid !== exp_vec) begin n_fail++; $display("FAIL m_rvalid: got %b, expected %b", m_rvalid, exp_vec); end
      n_checks++; if (m_rdata[g] !== data) begin n_fail++; $display("FAIL m_rdata: got %h, expected %h", m_rdata[g], data); end
      n_checks++; if (m_rresp[g] !== resp) begin n_fail++; $display("FAIL m_rresp: got %b, expected %b", m_rresp[g], resp); end
      n_checks++; if (s_rready !== m_rready[g]) begin n_fail++; $display("FAIL s_rready: got %b, expected %b", s_rready, m_rready[g]); end
      for (int i = 0; i < N; i++) begin
        if (i != g) begin
          n_checks++;
          if (m_rdata[i] !== '0 || m_rresp[i] !== '0) begin n_fail++; $display("FAIL other_r_m%0d: got data=%h resp=%b, expected 0", i, m_rdata[i], m_rresp[i]); end
        end
      end
      done = s_rvalid && m_rready[g];
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL r_handshake: got none within bound, expected one"); end
    @(posedge clk); #1;
    s_rvalid    = 1'b0;
    s_rdata     = '0;
    s_rresp     = '0;
    m_rready[g] = 1'b0;
`ifndef AXIL_ARB_RD_FIXED_PRIO_EN
    model_last  = g;
`endif
    @(negedge clk);
    n_checks++; if (outs_zero() !== 1'b1) begin n_fail++; $display("FAIL post_txn_idle: got gv=%b arv=%b rv=%b, expected all 0", grant_valid, s_arvalid, m_rvalid); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) m_araddr[i] = '0;
    apply_reset();
    rst_n = 1'b0;
    m_arvalid = '1;
    s_rvalid  = 1'b1;
    s_rdata   = 32'hFFFF_FFFF;
    #3;
    n_checks++; if (outs_zero() !== 1'b1) begin n_fail++; $display("FAIL reset_outputs: got gv=%b arv=%b, expected 0", grant_valid, s_arvalid); end
    n_checks++; if (grant_rd !== '0) begin n_fail++; $display("FAIL reset_grant_rd: got %0d, expected 0", grant_rd); end
    apply_reset();
  endtask

  task automatic test_single();
    m_araddr[0]  = 32'h10;
    m_arvalid[0] = 1'b1;
    do_txn(exp_winner(m_arvalid, model_last), 0, 0, 0, 32'hA5, OKAY);
  endtask

  task automatic test_contention();
    int exp_seq [4];
    apply_reset();
`ifdef AXIL_ARB_RD_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    m_araddr[0] = 32'h100;
    m_araddr[1] = 32'h200;
    m_arvalid   = 3'b011;
    for (int t = 0; t < 4; t++) begin
      do_txn(exp_seq[t], 0, 0, 0, 32'h1000 + t, OKAY);
      m_arvalid[1:0] = 2'b11;
    end
    m_arvalid = '0;
  endtask

  task automatic test_backpressure();
    m_araddr[1]  = 32'h44;
    m_arvalid[1] = 1'b1;
    do_txn(exp_winner(m_arvalid, model_last), 0, 0, 5, 32'h3C, OKAY);
  endtask

  task automatic test_slow_slave();
    m_araddr[0] = 32'hA0;
    m_araddr[1] = 32'hA1;
    m_araddr[2] = 32'hA2;
    m_arvalid   = 3'b111;
    do_txn(exp_winner(m_arvalid, model_last), 4, 0, 0, 32'h5555_0001, OKAY);
  endtask

  task automatic test_error_resp();
    m_arvalid = 3'b111;
    do_txn(exp_winner(m_arvalid, model_last), 0, 1, 0, 32'hBAD0_0001, SLVERR);
    do_txn(exp_winner(m_arvalid, model_last), 1, 0, 2, 32'hBAD0_0002, DECERR);
    do_txn(exp_winner(m_arvalid, model_last), 0, 0, 0, 32'h600D_0003, EXOKAY);
    m_arvalid = '0;
  endtask

  task automatic test_random();
    int g;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_arvalid[i] && $urandom_range(1, 0) == 1) begin
          m_araddr[i]  = $urandom;
          m_arvalid[i] = 1'b1;
        end
      end
      if (m_arvalid == '0) begin
        g = $urandom_range(N - 1, 0);
        m_araddr[g]  = $urandom;
        m_arvalid[g] = 1'b1;
      end
      do_txn(exp_winner(m_arvalid, model_last), $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(3, 0), $urandom, 2'($urandom_range(3, 0)));
    end
    m_arvalid = '0;
  endtask

  task automatic test_reset_mid();
    m_arvalid    = '0;
    m_araddr[1]  = 32'h77;
    m_arvalid[1] = 1'b1;
    @(posedge clk); #1;
    s_arready = 1'b1;
    @(posedge clk); #1;
    s_arready    = 1'b0;
    m_arvalid[1] = 1'b0;
    s_rvalid     = 1'b1;
    s_rdata      = 32'hDEAD_BEEF;
    m_rready     = '0;
    @(negedge clk);
    n_checks++; if (grant_valid !== 1'b1 || m_rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL mid_data_pending: got gv=%b rvalid=%b, expected 1/1", grant_valid, m_rvalid[1]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (outs_zero() !== 1'b1) begin n_fail++; $display("FAIL mid_reset_outputs: got gv=%b rv=%b, expected 0", grant_valid, m_rvalid); end
    n_checks++; if (grant_rd !== '0) begin n_fail++; $display("FAIL mid_reset_grant_rd: got %0d, expected 0", grant_rd); end
    s_rvalid = 1'b0;
    s_rdata  = '0;
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = N - 1;
    for (int i = 0; i < N; i++) m_araddr[i] = 32'hC0 + i;
    m_arvalid = 3'b111;
    do_txn(0, 0, 0, 0, 32'h0F0F_0F0F, OKAY);
    m_arvalid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_slow_slave();
    test_error_resp();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
